// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_pkg : shared BCD types, limits and scan-state helpers.   Rev 1.0
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX    = 4'd9;
  localparam int   NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_e;

  function automatic scan_state_e next_scan(input scan_state_e s);
    case (s)
      DIG0:    next_scan = DIG1;
      DIG1:    next_scan = DIG2;
      DIG2:    next_scan = DIG3;
      default: next_scan = DIG0;
    endcase
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit : one decade (clear/load/inc/dec, carry+borrow). BCD_DOWN_COUNT_EN
// enables the decrement path.                                   Rev 1.0
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output bcd_t       digit_o,
  output bcd_t       digit_d_o,
  output logic       inc_co_o,
  output logic       dec_co_o,
  output logic       load_err_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = (load_val_i > BCD_MAX) ? '0 : load_val_i;
    end else if (inc_i) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
`ifdef BCD_DOWN_COUNT_EN
    end else if (dec_i) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit_o    = digit_q;
  assign digit_d_o  = digit_d;
  assign inc_co_o   = inc_i && (digit_q == BCD_MAX);
  assign load_err_o = (load_val_i > BCD_MAX);

`ifdef BCD_DOWN_COUNT_EN
  assign dec_co_o = dec_i && (digit_q == '0);
`else
  logic unused_dec;
  assign unused_dec = dec_i;
  assign dec_co_o   = 1'b0;
`endif

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_scan_counter : 4-digit BCD counter with multiplexed 7-seg digit scan.
// Macro BCD_DOWN_COUNT_EN enables down counting via down_i.     Rev 1.0
// ---------------------------------------------------------------------------
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        tick_i,
  input  logic        down_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] count_o,
  output logic        carry_o,
  output logic        load_err_o,
  output logic [3:0]  val_o,
  output logic [3:0]  an_o
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic w_step;
  logic w_up;
  logic w_dn;

  assign w_step = en_i && tick_i && !clear_i && !load_i;

`ifdef BCD_DOWN_COUNT_EN
  assign w_up = w_step && !down_i;
  assign w_dn = w_step &&  down_i;
`else
  logic unused_down;
  assign unused_down = down_i;
  assign w_up = w_step;
  assign w_dn = 1'b0;
`endif

  bcd_t w_dig_q  [NUM_DIGITS];
  bcd_t w_dig_d  [NUM_DIGITS];
  logic w_inc_ci [NUM_DIGITS];
  logic w_dec_ci [NUM_DIGITS];
  logic w_inc_co [NUM_DIGITS];
  logic w_dec_co [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_err;

  assign w_inc_ci[0] = w_up;
  assign w_dec_ci[0] = w_dn;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i > 0) begin : g_chain
        assign w_inc_ci[i] = w_inc_co[i-1];
        assign w_dec_ci[i] = w_dec_co[i-1];
      end
      bcd_digit u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .load_i     (load_i),
        .load_val_i (load_val_i[4*i +: 4]),
        .inc_i      (w_inc_ci[i]),
        .dec_i      (w_dec_ci[i]),
        .digit_o    (w_dig_q[i]),
        .digit_d_o  (w_dig_d[i]),
        .inc_co_o   (w_inc_co[i]),
        .dec_co_o   (w_dec_co[i]),
        .load_err_o (w_err[i])
      );
      assign count_o[4*i +: 4] = w_dig_q[i];
    end
  endgenerate

  logic carry_q,    carry_d;
  logic load_err_q, load_err_d;

  // Wrap out of the top decade is the whole-counter wrap.
  assign carry_d    = w_inc_co[NUM_DIGITS-1] || w_dec_co[NUM_DIGITS-1];
  assign load_err_d = load_i && !clear_i && (|w_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign carry_o    = carry_q;
  assign load_err_o = load_err_q;

  scan_state_e   state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [3:0]    an_q;
  bcd_t          val_q;
  logic          w_adv;

  assign w_adv   = (pre_q == PRE_LAST);
  assign state_d = w_adv ? next_scan(state_q) : state_q;

  // val_o samples the next count so it tracks count_o on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIG0;
      pre_q   <= '0;
      an_q    <= 4'b1110;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= w_adv ? '0 : pre_q + PW'(1);
      an_q    <= ~(4'b0001 << state_d);
      val_q   <= w_dig_d[state_d];
    end
  end

  assign an_o  = an_q;
  assign val_o = val_q;

endmodule : bcd_scan_counter
`default_nettype wire
